alu_seq_core: RTL

Parametrised multi-cycle ALU for the processor datapath, the successor to the 32-bit stage-counter ALU. It adds a start/busy/done handshake, a configurable datapath width, and correct N-bit carry, borrow and overflow flags. It keeps the existing 6-bit opcode map and flag-register bit positions. Division and modulo use an iterative restoring divider; all other operations complete in a fixed two-edge latency.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the datapath sequencer and alu_seq_core.
// The master drives the request side; the core (slave) drives result, flags, busy and done.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             use_carry;
    logic             dec;
    logic [2:0]       shift_mode;
    logic [15:0]      fr_in;
    logic [WIDTH-1:0] result;
    logic [15:0]      fr_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op_code, op_a, op_b, use_carry, dec, shift_mode, fr_in,
        input  result, fr_out, busy, done
    );

    modport slave (
        input  start, op_code, op_a, op_b, use_carry, dec, shift_mode, fr_in,
        output result, fr_out, busy, done
    );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with start/busy/done handshake and N-bit carry/borrow flags.
// Define ALU_DIV_EN to build the iterative restoring divider used by DIV/MOD.
module alu_seq_core #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     wire_clock,
    input  logic     wire_reset_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

    localparam logic [5:0] OP_FLAGS = 6'b000110;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADD2  = 6'b011101;
    localparam logic [5:0] OP_SUB   = 6'b100001;
    localparam logic [5:0] OP_MUL   = 6'b100010;
    localparam logic [5:0] OP_DIV   = 6'b100011;
    localparam logic [5:0] OP_MOD   = 6'b100101;
    localparam logic [5:0] OP_INC   = 6'b100100;
    localparam logic [5:0] OP_CMP   = 6'b010110;
    localparam logic [5:0] OP_AND   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XOR   = 6'b010100;
    localparam logic [5:0] OP_NOT   = 6'b010101;
    localparam logic [5:0] OP_SHIFT = 6'b010000;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [15:0]      flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             latch;

    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q, dec_q;
    logic [2:0]       mode_q;
    logic [15:0]      fr_q;

    logic [WIDTH-1:0]   exec_res;
    logic [15:0]        exec_fr;
    logic               cin;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     amt, amt_neg;
    logic [WIDTH-1:0]   incdec, rol, ror;

    assign cin     = carry_q & fr_q[11];
    assign sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    assign diff    = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
    assign prod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign incdec  = dec_q ? (a_q - ONE) : (a_q + ONE);
    assign amt     = b_q[SHW-1:0];
    // amt_neg is (WIDTH - amt) mod WIDTH, so amt=0 collapses both rotates to a pass-through
    assign amt_neg = -amt;
    assign rol     = (a_q << amt) | (a_q >> amt_neg);
    assign ror     = (a_q >> amt) | (a_q << amt_neg);

`ifdef ALU_DIV_EN
    localparam logic [SHW:0] DIV_LAST = (SHW+1)'(WIDTH);
    logic [WIDTH-1:0] rem_q, quo_q, div_trial, div_val;
    logic [WIDTH:0]   div_shift;
    logic [SHW:0]     cnt_q;
    logic             div_ge, div_step;

    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    // when div_ge holds the true difference is below b, so the low WIDTH bits are exact
    assign div_trial = div_shift[WIDTH-1:0] - b_q;
    assign div_val   = (op_q == OP_MOD) ? rem_q : quo_q;
`endif

    always_comb begin
        exec_res = res_q;
        exec_fr  = fr_q;
        case (op_q)
            OP_FLAGS: exec_fr = fr_q;
            OP_ADD, OP_ADD2: begin
                exec_res    = sum[WIDTH-1:0];
                exec_fr[11] = sum[WIDTH];
                exec_fr[12] = ~|sum[WIDTH-1:0];
            end
            OP_SUB: begin
                exec_res    = diff[WIDTH-1:0];
                exec_fr[6]  = diff[WIDTH];
                exec_fr[12] = ~|diff[WIDTH-1:0];
            end
            OP_MUL: begin
                exec_res    = prod[WIDTH-1:0];
                exec_fr[10] = |prod[2*WIDTH-1:WIDTH];
                exec_fr[12] = ~|prod[WIDTH-1:0];
            end
            // reached only for a zero divisor or when no divider is built
            OP_DIV, OP_MOD: begin
                exec_res   = '0;
                exec_fr[9] = 1'b1;
            end
            OP_INC: begin
                exec_res    = incdec;
                exec_fr[12] = ~|incdec;
            end
            OP_CMP: begin
                if (a_q == b_q)     exec_fr[15:13] = 3'b001;
                else if (a_q < b_q) exec_fr[15:13] = 3'b010;
                else                exec_fr[15:13] = 3'b100;
            end
            OP_AND: begin
                exec_res    = a_q & b_q;
                exec_fr[12] = ~|(a_q & b_q);
            end
            OP_OR: begin
                exec_res    = a_q | b_q;
                exec_fr[12] = ~|(a_q | b_q);
            end
            OP_XOR: begin
                exec_res    = a_q ^ b_q;
                exec_fr[12] = ~|(a_q ^ b_q);
            end
            OP_NOT: begin
                exec_res    = ~a_q;
                exec_fr[12] = ~|(~a_q);
            end
            OP_SHIFT: begin
                casez (mode_q)
                    3'b00?:  exec_res = a_q << amt;
                    3'b01?:  exec_res = a_q >> amt;
                    3'b10?:  exec_res = rol;
                    default: exec_res = ror;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        latch   = 1'b0;
`ifdef ALU_DIV_EN
        div_step = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    latch   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EXEC;
`ifdef ALU_DIV_EN
                    if ((bus.op_code == OP_DIV || bus.op_code == OP_MOD) && bus.op_b != '0)
                        state_d = DIV;
`endif
                end
            end
            EXEC: begin
                res_d   = exec_res;
                flags_d = exec_fr;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DIV: begin
`ifdef ALU_DIV_EN
                if (cnt_q == DIV_LAST) begin
                    res_d       = div_val;
                    flags_d     = fr_q;
                    flags_d[9]  = 1'b0;
                    flags_d[12] = ~|div_val;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    div_step = 1'b1;
                end
`else
                busy_d  = 1'b0;
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wire_clock) begin
        if (!wire_reset_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge wire_clock) begin
        if (latch) begin
            op_q    <= bus.op_code;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            carry_q <= bus.use_carry;
            dec_q   <= bus.dec;
            mode_q  <= bus.shift_mode;
            fr_q    <= bus.fr_in;
        end
`ifdef ALU_DIV_EN
        if (latch) begin
            rem_q <= '0;
            quo_q <= bus.op_a;
            cnt_q <= '0;
        end else if (div_step) begin
            cnt_q <= cnt_q + (SHW+1)'(1);
            if (div_ge) begin
                rem_q <= div_trial;
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= div_shift[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign bus.result = res_q;
    assign bus.fr_out = flags_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
